// File: rtl/sdram_arb_pkg.sv
// Shared types and default sizing for the SDRAM port arbiter.
package sdram_arb_pkg;

   localparam int ADDR_W_DEF   = 25;
   localparam int DATA_W_DEF   = 16;
   localparam int LEN_W_DEF    = 12;
   localparam int MAX_OUTS_DEF = 8;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_RD_ISSUE = 2'd1,
      ST_RD_DRAIN = 2'd2,
      ST_WR_ISSUE = 2'd3
   } arb_state_e;

endpackage

// File: rtl/burst_addr_gen.sv
// Burst address/length register with issued-word counter; shared by the read and write ports.
module burst_addr_gen
   import sdram_arb_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int LEN_W  = LEN_W_DEF
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic [ADDR_W-1:0] load_addr,
   input  logic [LEN_W-1:0]  load_len,
   input  logic              accept,
   output logic [ADDR_W-1:0] addr,
   output logic [LEN_W-1:0]  len,
   output logic              more,
   output logic              last,
   output logic              len_zero
);

   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [LEN_W-1:0]  cnt_q, cnt_d;
   logic [LEN_W-1:0]  len_q, len_d;
   logic [LEN_W-1:0]  cnt_inc;

   assign cnt_inc = cnt_q + LEN_W'(1);

   always_comb begin
      addr_d = addr_q;
      cnt_d  = cnt_q;
      len_d  = len_q;
      if (load) begin
         addr_d = load_addr;
         cnt_d  = '0;
         len_d  = load_len;
      end else if (accept) begin
         // address wraps naturally at the top of the SDRAM
         addr_d = addr_q + ADDR_W'(1);
         cnt_d  = cnt_inc;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q <= '0;
         cnt_q  <= '0;
         len_q  <= '0;
      end else begin
         addr_q <= addr_d;
         cnt_q  <= cnt_d;
         len_q  <= len_d;
      end
   end

   assign addr     = addr_q;
   assign len      = len_q;
   assign more     = (cnt_q < len_q);
   assign last     = (cnt_inc == len_q);
   assign len_zero = (len_q == '0);

endmodule

// File: rtl/sdram_port_arbiter.sv
// Shares one SDRAM Avalon-MM slave between the VGA line fetcher (read, priority)
// and the frame loader (write), sequencing bursts and routing read data back.
module sdram_port_arbiter
   import sdram_arb_pkg::*;
#(
   parameter int ADDR_W   = ADDR_W_DEF,
   parameter int DATA_W   = DATA_W_DEF,
   parameter int LEN_W    = LEN_W_DEF,
   parameter int MAX_OUTS = MAX_OUTS_DEF
)(
   input  logic              iCLK,
   input  logic              iRST_N,
   input  logic              iRD_REQ,
   input  logic [ADDR_W-1:0] iRD_ADDR,
   input  logic [LEN_W-1:0]  iRD_LEN,
   output logic              oRD_ACK,
   output logic [DATA_W-1:0] oRD_DATA,
   output logic              oRD_DATAVALID,
   output logic              oRD_DONE,
   input  logic              iWR_REQ,
   input  logic [ADDR_W-1:0] iWR_ADDR,
   input  logic [LEN_W-1:0]  iWR_LEN,
   output logic              oWR_ACK,
   input  logic [DATA_W-1:0] iWR_DATA,
   input  logic              iWR_VALID,
   output logic              oWR_POP,
   output logic              oWR_DONE,
   output logic [ADDR_W-1:0] oAV_ADDR,
   output logic              oAV_READ,
   output logic              oAV_WRITE,
   output logic [DATA_W-1:0] oAV_WRDATA,
   input  logic              iAV_WAITREQ,
   input  logic [DATA_W-1:0] iAV_RDDATA,
   input  logic              iAV_RDVALID,
   output logic              oBUSY
);

   localparam int OUTS_W = $clog2(MAX_OUTS) + 1;

   arb_state_e        state_q, state_d;
   logic              rd_ack_q, rd_ack_d;
   logic              wr_ack_q, wr_ack_d;
   logic              rd_done_q, rd_done_d;
   logic              wr_done_q, wr_done_d;
   logic              rd_valid_q, rd_valid_d;
   logic [DATA_W-1:0] rd_data_q, rd_data_d;
   logic [OUTS_W-1:0] outs_q, outs_d;
   logic [LEN_W-1:0]  ret_q, ret_d;
   logic [LEN_W-1:0]  ret_inc;

   logic              load;
   logic [ADDR_W-1:0] load_addr;
   logic [LEN_W-1:0]  load_len;
   logic              av_read, av_write, accept, rd_accept;
   logic              ret_hit;
   logic [ADDR_W-1:0] gen_addr;
   logic [LEN_W-1:0]  gen_len;
   logic              gen_more, gen_last, gen_len_zero;

   burst_addr_gen #(
      .ADDR_W (ADDR_W),
      .LEN_W  (LEN_W)
   ) u_addr_gen (
      .clk       (iCLK),
      .rst_n     (iRST_N),
      .load      (load),
      .load_addr (load_addr),
      .load_len  (load_len),
      .accept    (accept),
      .addr      (gen_addr),
      .len       (gen_len),
      .more      (gen_more),
      .last      (gen_last),
      .len_zero  (gen_len_zero)
   );

   // Returns are only meaningful while a read burst owns the port.
   assign ret_hit   = iAV_RDVALID & ((state_q == ST_RD_ISSUE) | (state_q == ST_RD_DRAIN));
   assign ret_inc   = ret_q + LEN_W'(1);
   assign accept    = (av_read | av_write) & ~iAV_WAITREQ;
   assign rd_accept = av_read & ~iAV_WAITREQ;

   always_comb begin
      state_d   = state_q;
      rd_ack_d  = 1'b0;
      wr_ack_d  = 1'b0;
      rd_done_d = 1'b0;
      wr_done_d = 1'b0;
      load      = 1'b0;
      load_addr = iRD_ADDR;
      load_len  = iRD_LEN;
      av_read   = 1'b0;
      av_write  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (iRD_REQ) begin
               load     = 1'b1;
               rd_ack_d = 1'b1;
               state_d  = ST_RD_ISSUE;
            end else if (iWR_REQ) begin
               load      = 1'b1;
               load_addr = iWR_ADDR;
               load_len  = iWR_LEN;
               wr_ack_d  = 1'b1;
               state_d   = ST_WR_ISSUE;
            end
         end
         ST_RD_ISSUE: begin
            av_read = gen_more & (outs_q < OUTS_W'(MAX_OUTS));
            if (gen_len_zero) begin
               rd_done_d = 1'b1;
               state_d   = ST_IDLE;
            end else if (rd_accept & gen_last) begin
               state_d = ST_RD_DRAIN;
            end
         end
         ST_RD_DRAIN: begin
            if (ret_hit & (ret_inc == gen_len)) begin
               rd_done_d = 1'b1;
               state_d   = ST_IDLE;
            end
         end
         ST_WR_ISSUE: begin
            av_write = iWR_VALID & gen_more;
            if (gen_len_zero) begin
               wr_done_d = 1'b1;
               state_d   = ST_IDLE;
            end else if (accept & gen_last) begin
               wr_done_d = 1'b1;
               state_d   = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      outs_d = outs_q;
      if (rd_accept & ~ret_hit)
         outs_d = outs_q + OUTS_W'(1);
      else if (~rd_accept & ret_hit & (outs_q != '0))
         outs_d = outs_q - OUTS_W'(1);

      ret_d = ret_q;
      if (load)
         ret_d = '0;
      else if (ret_hit)
         ret_d = ret_inc;

      rd_valid_d = ret_hit;
      rd_data_d  = ret_hit ? iAV_RDDATA : rd_data_q;
   end

   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         state_q    <= ST_IDLE;
         rd_ack_q   <= 1'b0;
         wr_ack_q   <= 1'b0;
         rd_done_q  <= 1'b0;
         wr_done_q  <= 1'b0;
         rd_valid_q <= 1'b0;
         rd_data_q  <= '0;
         outs_q     <= '0;
         ret_q      <= '0;
      end else begin
         state_q    <= state_d;
         rd_ack_q   <= rd_ack_d;
         wr_ack_q   <= wr_ack_d;
         rd_done_q  <= rd_done_d;
         wr_done_q  <= wr_done_d;
         rd_valid_q <= rd_valid_d;
         rd_data_q  <= rd_data_d;
         outs_q     <= outs_d;
         ret_q      <= ret_d;
      end
   end

   assign oRD_ACK       = rd_ack_q;
   assign oWR_ACK       = wr_ack_q;
   assign oRD_DONE      = rd_done_q;
   assign oWR_DONE      = wr_done_q;
   assign oRD_DATA      = rd_data_q;
   assign oRD_DATAVALID = rd_valid_q;
   assign oAV_ADDR      = gen_addr;
   assign oAV_READ      = av_read;
   assign oAV_WRITE     = av_write;
   assign oAV_WRDATA    = (state_q == ST_WR_ISSUE) ? iWR_DATA : '0;
   assign oWR_POP       = av_write & ~iAV_WAITREQ;
   assign oBUSY         = (state_q != ST_IDLE);

endmodule
